// File: rtl/or_reduce_pkg.sv
// or_reduce shared constants and tree sizing helpers.
// Build with OR_REDUCE_REG_EN defined to register res_q/any_q.
package or_reduce_pkg;

  localparam int OR_NUM_DEF   = 8;
  localparam int OR_WIDTH_DEF = 8;

  function automatic int tree_depth(input int n);
    int d;
    d = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << d) < n) d++;
    return d;
  endfunction

  // Node count at tree level l; odd leftovers carry up.
  function automatic int level_cnt(input int n, input int l);
    int c;
    c = n;
    for (int i = 0; i < l; i++)
      c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/or_reduce_if.sv
// or_reduce bus: source vectors, capture enable and results.
// Slave side is the reducer; master side drives src/en.
interface or_reduce_if
  import or_reduce_pkg::*;
#(
  parameter int NUM   = OR_NUM_DEF,
  parameter int WIDTH = OR_WIDTH_DEF
);

  logic [WIDTH-1:0] src [NUM];
  logic             en;
  logic [WIDTH-1:0] res;
  logic             any;
  logic [NUM-1:0]   src_nz;
  logic [WIDTH-1:0] res_q;
  logic             any_q;

  modport master (
    output src, en,
    input  res, any, src_nz, res_q, any_q
  );

  modport slave (
    input  src, en,
    output res, any, src_nz, res_q, any_q
  );

endinterface

// File: rtl/or_reduce_node.sv
// One WIDTH-bit node of the OR tree.
// Pure bitwise OR, no width change.
module or_reduce_node #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a | b;

endmodule

// File: rtl/or_reduce.sv
// Balanced OR tree over NUM vectors with optional output register.
// OR_REDUCE_REG_EN defined: res_q/any_q flopped; else passthrough.
module or_reduce
  import or_reduce_pkg::*;
#(
  parameter int NUM   = OR_NUM_DEF,
  parameter int WIDTH = OR_WIDTH_DEF
) (
  input logic         clk,
  input logic         rstn,
  or_reduce_if.slave  bus
);

  localparam int DEPTH = tree_depth(NUM);

  logic [WIDTH-1:0] lvl [DEPTH+1][NUM];
  logic [WIDTH-1:0] res;
  logic             any;

  for (genvar i = 0; i < NUM; i++) begin : g_leaf
    assign lvl[0][i]      = bus.src[i];
    assign bus.src_nz[i]  = |bus.src[i];
  end

  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int CI = level_cnt(NUM, l);
    localparam int CO = level_cnt(NUM, l + 1);
    for (genvar j = 0; j < NUM; j++) begin : g_n
      if (j < CO && 2 * j + 1 < CI) begin : g_or
        or_reduce_node #(.WIDTH(WIDTH)) u_node (
          .a (lvl[l][2*j]),
          .b (lvl[l][2*j+1]),
          .y (lvl[l+1][j])
        );
      end else if (j < CO) begin : g_pass
        assign lvl[l+1][j] = lvl[l][2*j];
      end else begin : g_zero
        assign lvl[l+1][j] = '0;
      end
    end
  end

  assign res     = lvl[DEPTH][0];
  assign any     = |res;
  assign bus.res = res;
  assign bus.any = any;

`ifdef OR_REDUCE_REG_EN
  logic [WIDTH-1:0] res_hold_d, res_hold_q;
  logic             any_hold_d, any_hold_q;

  always_comb begin
    res_hold_d = res_hold_q;
    any_hold_d = any_hold_q;
    if (bus.en) begin
      res_hold_d = res;
      any_hold_d = any;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_hold_q <= '0;
      any_hold_q <= 1'b0;
    end else begin
      res_hold_q <= res_hold_d;
      any_hold_q <= any_hold_d;
    end
  end

  assign bus.res_q = res_hold_q;
  assign bus.any_q = any_hold_q;
`else
  logic unused_ctl;
  assign unused_ctl = ^{clk, rstn, bus.en};
  assign bus.res_q  = res;
  assign bus.any_q  = any;
`endif

endmodule

// File: tb/tb_or_reduce.sv
// Directed self-checking bench for or_reduce (NUM 8/3/1).
// Register checks follow OR_REDUCE_REG_EN.
module tb_or_reduce;
  import or_reduce_pkg::*;

  logic clk;
  logic rstn;
  int   n_pass;
  int   n_total;

  or_reduce_if #(.NUM(8), .WIDTH(8)) bus8 ();
  or_reduce_if #(.NUM(3), .WIDTH(4)) bus3 ();
  or_reduce_if #(.NUM(1), .WIDTH(4)) bus1 ();

  or_reduce #(.NUM(8), .WIDTH(8)) u8 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus8)
  );

  or_reduce #(.NUM(3), .WIDTH(4)) u3 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus3)
  );

  or_reduce #(.NUM(1), .WIDTH(4)) u1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear8();
    for (int i = 0; i < 8; i++) bus8.src[i] = 8'h00;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus8.en = 1'b1;
    clear8();
    #1;
    n_total++;
    if (bus8.res !== 8'h00 || bus8.any !== 1'b0)
      $display("FAIL rst_comb res=%h any=%b want 00/0",
               bus8.res, bus8.any);
    else n_pass++;
    n_total++;
    if (bus8.src_nz !== 8'h00)
      $display("FAIL rst_nz got=%h want 00", bus8.src_nz);
    else n_pass++;
    n_total++;
    if (bus8.res_q !== 8'h00 || bus8.any_q !== 1'b0)
      $display("FAIL rst_q res_q=%h any_q=%b want 00/0",
               bus8.res_q, bus8.any_q);
    else n_pass++;
    bus8.src[3] = 8'h10;
    @(posedge clk);
    #1;
    n_total++;
    if (bus8.res !== 8'h10 || bus8.src_nz !== 8'h08)
      $display("FAIL rst_follow res=%h nz=%h want 10/08",
               bus8.res, bus8.src_nz);
    else n_pass++;
    n_total++;
`ifdef OR_REDUCE_REG_EN
    if (bus8.res_q !== 8'h00 || bus8.any_q !== 1'b0)
      $display("FAIL rst_hold res_q=%h any_q=%b want 00/0",
               bus8.res_q, bus8.any_q);
    else n_pass++;
`else
    if (bus8.res_q !== 8'h10 || bus8.any_q !== 1'b1)
      $display("FAIL rst_pass res_q=%h any_q=%b want 10/1",
               bus8.res_q, bus8.any_q);
    else n_pass++;
`endif
    @(negedge clk);
    rstn = 1'b1;
    bus8.en = 1'b0;
    clear8();
  endtask

  task automatic test_onehot();
    @(negedge clk);
    for (int i = 0; i < 8; i++) bus8.src[i] = 8'(1 << i);
    #1;
    n_total++;
    if (bus8.res !== 8'hFF || bus8.any !== 1'b1)
      $display("FAIL onehot res=%h any=%b want FF/1",
               bus8.res, bus8.any);
    else n_pass++;
    n_total++;
    if (bus8.src_nz !== 8'hFF)
      $display("FAIL onehot_nz got=%h want FF", bus8.src_nz);
    else n_pass++;
  endtask

  task automatic test_single();
    @(negedge clk);
    clear8();
    bus8.src[5] = 8'h20;
    #1;
    n_total++;
    if (bus8.res !== 8'h20 || bus8.any !== 1'b1)
      $display("FAIL single res=%h any=%b want 20/1",
               bus8.res, bus8.any);
    else n_pass++;
    n_total++;
    if (bus8.src_nz !== 8'h20)
      $display("FAIL single_nz got=%h want 20", bus8.src_nz);
    else n_pass++;
    clear8();
    #1;
    n_total++;
    if (bus8.res !== 8'h00 || bus8.any !== 1'b0 ||
        bus8.src_nz !== 8'h00)
      $display("FAIL zero res=%h any=%b nz=%h want 00/0/00",
               bus8.res, bus8.any, bus8.src_nz);
    else n_pass++;
  endtask

  task automatic test_patterns();
    clear8();
    bus8.src[0] = 8'h0F;
    bus8.src[7] = 8'hF0;
    #1;
    n_total++;
    if (bus8.res !== 8'hFF || bus8.src_nz !== 8'h81)
      $display("FAIL pat_a res=%h nz=%h want FF/81",
               bus8.res, bus8.src_nz);
    else n_pass++;
    clear8();
    bus8.src[2] = 8'h01;
    bus8.src[6] = 8'h01;
    bus8.src[4] = 8'h80;
    #1;
    n_total++;
    if (bus8.res !== 8'h81 || bus8.src_nz !== 8'h54)
      $display("FAIL pat_b res=%h nz=%h want 81/54",
               bus8.res, bus8.src_nz);
    else n_pass++;
    clear8();
    bus8.src[6] = 8'h42;
    bus8.src[1] = 8'h18;
    #1;
    n_total++;
    if (bus8.res !== 8'h5A || bus8.any !== 1'b1)
      $display("FAIL pat_c res=%h any=%b want 5A/1",
               bus8.res, bus8.any);
    else n_pass++;
  endtask

  task automatic test_reg();
    @(negedge clk);
    clear8();
    bus8.src[0] = 8'h81;
    bus8.en = 1'b1;
`ifdef OR_REDUCE_REG_EN
    @(posedge clk);
    #1;
    n_total++;
    if (bus8.res_q !== 8'h81 || bus8.any_q !== 1'b1)
      $display("FAIL cap res_q=%h any_q=%b want 81/1",
               bus8.res_q, bus8.any_q);
    else n_pass++;
    @(negedge clk);
    bus8.en = 1'b0;
    bus8.src[0] = 8'h02;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (bus8.res_q !== 8'h81 || bus8.any_q !== 1'b1)
        $display("FAIL hold%0d res_q=%h any_q=%b want 81/1",
                 k, bus8.res_q, bus8.any_q);
      else n_pass++;
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_total++;
    if (bus8.res_q !== 8'h00 || bus8.any_q !== 1'b0)
      $display("FAIL async_rst res_q=%h any_q=%b want 00/0",
               bus8.res_q, bus8.any_q);
    else n_pass++;
    #2;
    rstn = 1'b1;
    @(negedge clk);
    bus8.en = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (bus8.res_q !== 8'h02 || bus8.any_q !== 1'b1)
      $display("FAIL post_rst res_q=%h any_q=%b want 02/1",
               bus8.res_q, bus8.any_q);
    else n_pass++;
`else
    #1;
    n_total++;
    if (bus8.res_q !== 8'h81 || bus8.any_q !== 1'b1)
      $display("FAIL pass_a res_q=%h any_q=%b want 81/1",
               bus8.res_q, bus8.any_q);
    else n_pass++;
    bus8.en = 1'b0;
    bus8.src[0] = 8'h02;
    #1;
    n_total++;
    if (bus8.res_q !== 8'h02 || bus8.any_q !== 1'b1)
      $display("FAIL pass_b res_q=%h any_q=%b want 02/1",
               bus8.res_q, bus8.any_q);
    else n_pass++;
    bus8.src[0] = 8'h00;
    #1;
    n_total++;
    if (bus8.res_q !== 8'h00 || bus8.any_q !== 1'b0)
      $display("FAIL pass_c res_q=%h any_q=%b want 00/0",
               bus8.res_q, bus8.any_q);
    else n_pass++;
`endif
    @(negedge clk);
    bus8.en = 1'b0;
  endtask

  task automatic test_small();
    bus3.src[0] = 4'h1;
    bus3.src[1] = 4'h4;
    bus3.src[2] = 4'h8;
    bus1.src[0] = 4'hA;
    #1;
    n_total++;
    if (bus3.res !== 4'hD || bus3.src_nz !== 3'b111)
      $display("FAIL n3 res=%h nz=%b want D/111",
               bus3.res, bus3.src_nz);
    else n_pass++;
    bus3.src[0] = 4'h0;
    bus3.src[1] = 4'h0;
    bus3.src[2] = 4'h6;
    #1;
    n_total++;
    if (bus3.res !== 4'h6 || bus3.src_nz !== 3'b100)
      $display("FAIL n3_odd res=%h nz=%b want 6/100",
               bus3.res, bus3.src_nz);
    else n_pass++;
    n_total++;
    if (bus1.res !== 4'hA || bus1.any !== 1'b1 ||
        bus1.src_nz !== 1'b1)
      $display("FAIL n1 res=%h any=%b nz=%b want A/1/1",
               bus1.res, bus1.any, bus1.src_nz);
    else n_pass++;
    bus1.src[0] = 4'h0;
    #1;
    n_total++;
    if (bus1.res !== 4'h0 || bus1.any !== 1'b0)
      $display("FAIL n1_zero res=%h any=%b want 0/0",
               bus1.res, bus1.any);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rstn    = 1'b0;
    bus8.en = 1'b0;
    bus3.en = 1'b0;
    bus1.en = 1'b0;
    clear8();
    for (int i = 0; i < 3; i++) bus3.src[i] = 4'h0;
    bus1.src[0] = 4'h0;
    test_reset();
    test_onehot();
    test_single();
    test_patterns();
    test_reg();
    test_small();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
